// File: rtl/divider32by16_pkg.sv
// Shared definitions for the signed divider: widths, FSM encoding,
// saturation constants and sign-magnitude helpers (also used by the multiplier).
package divider32by16_pkg;

  localparam int DW   = 16;             // divisor / quotient / remainder width
  localparam int ITER = 2 * DW;         // quotient bits produced, one per cycle
  localparam int CW   = $clog2(ITER);   // iteration counter width

  localparam logic [DW-1:0] SAT_POS = 16'h7FFF;
  localparam logic [DW-1:0] SAT_NEG = 16'h8000;

  typedef enum logic [2:0] {
    IDLE,
    CONVERT,
    DIVIDE,
    FIX,
    DONE
  } state_e;

  // Magnitude of a 2*DW-bit two's-complement value; the most negative value
  // maps onto its own bit pattern, which is the correct unsigned magnitude.
  function automatic logic [2*DW-1:0] mag_wide(input logic [2*DW-1:0] v);
    return v[2*DW-1] ? (~v + 1'b1) : v;
  endfunction

  // Magnitude of a DW-bit two's-complement value, widened by one bit so the
  // most negative value (-2^(DW-1)) is representable.
  function automatic logic [DW:0] mag_narrow(input logic [DW-1:0] v);
    logic [DW:0] ext;
    ext = {v[DW-1], v};
    return ext[DW] ? (~ext + 1'b1) : ext;
  endfunction

  // Restore two's-complement form from a magnitude and a sign.
  function automatic logic [DW-1:0] apply_sign(input logic [DW-1:0] m, input logic neg);
    return neg ? (~m + 1'b1) : m;
  endfunction

endpackage

// File: rtl/divider32by16.sv
// Iterative signed divider: 32-bit dividend / 16-bit divisor, restoring
// shift-subtract on magnitudes, saturated 16-bit quotient, exact remainder.
module divider32by16
  import divider32by16_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2*DW-1:0] dividend_in32bit,
  input  logic [DW-1:0]   divisor_in16bit,
  output logic            busy,
  output logic            done,
  output logic [DW-1:0]   quotient_out16bit,
  output logic [DW-1:0]   remainder_out16bit,
  output logic            overflow,
  output logic            div_zero
);

  // Largest quotient magnitudes that fit without saturation.
  localparam logic [2*DW-1:0] POS_LIM = {{DW{1'b0}}, SAT_POS};
  localparam logic [2*DW-1:0] NEG_LIM = {{DW{1'b0}}, SAT_NEG};

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  // Holds the raw dividend, then its magnitude; during DIVIDE dividend bits
  // shift out of the top while quotient bits shift in at the bottom.
  logic [2*DW-1:0] dvd_q, dvd_d;
  logic [DW:0]     dsr_q, dsr_d;        // raw divisor (sign-extended), then magnitude
  logic [DW-1:0]   rem_q, rem_d;        // partial remainder, always < divisor magnitude
  logic            res_neg_q, res_neg_d;
  logic            dvd_neg_q, dvd_neg_d;
  logic [DW-1:0]   quotient_q, quotient_d;
  logic [DW-1:0]   remainder_q, remainder_d;
  logic            overflow_q, overflow_d;
  logic            div_zero_q, div_zero_d;
  logic [DW:0]     rem_shift;           // 17-bit trial value for the subtract

  // Next-state and datapath: every target defaults to hold, then the state overrides.
  always_comb begin
    // NOTE: assigning every _d a default first keeps this block purely
    // combinational; a path that skipped an assignment would infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    rem_d       = rem_q;
    res_neg_d   = res_neg_q;
    dvd_neg_d   = dvd_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    overflow_d  = overflow_q;
    div_zero_d  = div_zero_q;
    rem_shift   = {rem_q, dvd_q[2*DW-1]};

    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d      = dividend_in32bit;
          dsr_d      = {divisor_in16bit[DW-1], divisor_in16bit};
          overflow_d = 1'b0;
          div_zero_d = 1'b0;
          state_d    = CONVERT;
        end
      end

      CONVERT: begin
        dvd_d     = mag_wide(dvd_q);
        dsr_d     = mag_narrow(dsr_q[DW-1:0]);
        res_neg_d = dvd_q[2*DW-1] ^ dsr_q[DW-1];
        dvd_neg_d = dvd_q[2*DW-1];
        rem_d     = '0;
        cnt_d     = CW'(ITER - 1);
        state_d   = (dsr_q[DW-1:0] == '0) ? FIX : DIVIDE;
      end

      DIVIDE: begin
        if (rem_shift >= dsr_q) begin
          rem_d = DW'(rem_shift - dsr_q);
          dvd_d = {dvd_q[2*DW-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[DW-1:0];
          dvd_d = {dvd_q[2*DW-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIX;
      end

      FIX: begin
        overflow_d = 1'b0;
        if (dsr_q == '0) begin
          quotient_d  = dvd_neg_q ? SAT_NEG : SAT_POS;
          remainder_d = '0;
          div_zero_d  = 1'b1;
        end else begin
          div_zero_d  = 1'b0;
          remainder_d = apply_sign(rem_q, dvd_neg_q);
          if (res_neg_q && dvd_q > NEG_LIM) begin
            quotient_d = SAT_NEG;
            overflow_d = 1'b1;
          end else if (!res_neg_q && dvd_q > POS_LIM) begin
            quotient_d = SAT_POS;
            overflow_d = 1'b1;
          end else begin
            quotient_d = apply_sign(dvd_q[DW-1:0], res_neg_q);
          end
        end
        state_d = DONE;
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      res_neg_q   <= 1'b0;
      dvd_neg_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      overflow_q  <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      rem_q       <= rem_d;
      res_neg_q   <= res_neg_d;
      dvd_neg_q   <= dvd_neg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      overflow_q  <= overflow_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign busy               = (state_q != IDLE);
  assign done               = (state_q == DONE);
  assign quotient_out16bit  = quotient_q;
  assign remainder_out16bit = remainder_q;
  assign overflow           = overflow_q;
  assign div_zero           = div_zero_q;

endmodule
